rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each data channel.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SW, default $clog2(N), width of the source index.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-006 mode  input  1  arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-007 in_data  input  N*WIDTH  channel i data occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  N  channel i presents a word.
REQ-009 in_ready  output  N  channel i word is taken this cycle; combinational.
REQ-010 out_data  output  WIDTH  registered selected word.
REQ-011 out_src  output  SW  registered index of the channel that supplied out_data.
REQ-012 out_valid  output  1  registered; out_data/out_src hold a word.
REQ-013 out_ready  input  1  downstream accepts the output word this cycle.

Function
REQ-014 accept = !out_valid || out_ready, combinational.
REQ-015 grant: one-hot over N, nonzero only if accept and |in_valid; at most one bit set.
REQ-016 mode=0: grant selects lowest index i with in_valid[i]=1.
REQ-017 mode=1: grant selects first i with in_valid[i]=1 searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (mod N).
REQ-018 in_ready = grant; a channel transfers when in_valid[i] && in_ready[i].
REQ-019 On a transfer from channel g: next cycle out_data = channel g data, out_src = g, out_valid = 1 (latency exactly 1 cycle).
REQ-020 accept=1 with no in_valid: out_valid becomes 0; out_data and out_src hold their previous values.
REQ-021 accept=0 (out_valid=1, out_ready=0): out_data, out_src, out_valid held stable; in_ready all 0.
REQ-022 Simultaneous out_ready=1 and new transfer: old word leaves and new word loads in same edge; full throughput of one word per cycle.
REQ-023 ptr (SW bits) updates only on a transfer and only when mode=1: ptr <= (g == N-1) ? 0 : g+1 (wrap-around).
REQ-024 mode=0 transfers leave ptr unchanged; mode change takes effect for the arbitration in the same cycle it is applied.
REQ-025 in_valid and in_data of non-granted channels have no effect on state.
REQ-026 No starvation in mode=1: a continuously valid channel is granted within N transfers.

Reset
REQ-027 While rst_n=0 at a rising edge: out_valid <= 0, out_data <= 0, out_src <= 0, ptr <= 0.
REQ-028 in_ready is 0 during any cycle rst_n=0, independent of accept.
REQ-029 Reset mid-operation discards a held output word; no transfer is counted in that cycle.
REQ-030 First cycle after reset release, mode=1 arbitration starts at channel 0.

Verification
REQ-031 Reset: rst_n=0 two cycles with all in_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0000.
REQ-032 Round-robin: N=4, mode=1, in_valid=1111 constant, out_ready=1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, out_valid=1 every cycle from cycle 1.
REQ-033 Fixed priority: mode=0, in_valid=0110, out_ready=1 -> out_src=1 every cycle; in_ready=0010 every cycle.
REQ-034 Backpressure: word 0xDEADBEEF from ch2 loaded, out_ready=0 for 3 cycles -> out_data=0xDEADBEEF, out_src=2 held; in_ready=0000; on out_ready=1 next word loads same edge.
REQ-035 Wrap/skip: mode=1, ptr=3 after grant to ch2, in_valid=0101 -> grants ch0 then ch2 then ch0; ptr wraps 3->1->3->1.
REQ-036 Reset mid-stream: out_valid=1, out_ready=0, rst_n pulsed low one cycle -> out_valid=0 next cycle, ptr=0, next grant with in_valid=1111 is ch0.

Source files
------------

// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
// N-input arbiter/multiplexer feeding a single registered output slot.
// Each cycle in which the output slot can take a word, one valid channel is
// granted. The pick is either fixed priority (lowest index) or round-robin
// from a rotating pointer. The granted word appears on the output one cycle
// later.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   mode       : 0 = fixed priority, 1 = round-robin
//   in_data    : N packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel word present
//   in_ready   : per-channel grant (combinational), word taken this cycle
//   out_data   : registered selected word
//   out_src    : registered index of the supplying channel
//   out_valid  : registered, output slot holds a word
//   out_ready  : downstream consumes the output word this cycle
// -----------------------------------------------------------------------------
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

    // Returns {found, index} of the lowest set bit of vec.
    function automatic logic [SW:0] f_pick_lowest(input logic [N-1:0] vec);
        logic [SW:0] res;
        res = '0;
        // Descending scan so the lowest set bit is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, SW'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_src;
    logic             r_out_valid;
    logic [SW-1:0]    r_ptr;

    logic             w_accept;
    logic             w_arb_en;
    logic [N-1:0]     w_rr_mask;
    logic [SW:0]      w_pick_hi;
    logic [SW:0]      w_pick_all;
    logic             w_xfer;
    logic [SW-1:0]    w_gidx;
    logic [N-1:0]     w_grant;
    logic [WIDTH-1:0] w_sel_data;

    // Output slot can take a word when empty or being drained; never in reset.
    assign w_accept = !r_out_valid || out_ready;
    assign w_arb_en = rst_n && w_accept;

    // Round-robin: channels at or above ptr form the first search window.
    // In fixed-priority mode the window is all channels, so the upper pick
    // is simply the lowest valid index.
    always_comb begin
        w_rr_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (mode) begin
                w_rr_mask[i] = (SW'(i) >= r_ptr);
            end else begin
                w_rr_mask[i] = 1'b1;
            end
        end
    end

    assign w_pick_hi  = f_pick_lowest(in_valid & w_rr_mask);
    assign w_pick_all = f_pick_lowest(in_valid);

    // Choose the windowed pick if any, else wrap around to the lowest valid.
    always_comb begin
        w_xfer = 1'b0;
        w_gidx = '0;
        if (!w_arb_en) begin
            w_xfer = 1'b0;
            w_gidx = '0;
        end else if (w_pick_hi[SW]) begin
            w_xfer = 1'b1;
            w_gidx = w_pick_hi[SW-1:0];
        end else if (w_pick_all[SW]) begin
            w_xfer = 1'b1;
            w_gidx = w_pick_all[SW-1:0];
        end else begin
            w_xfer = 1'b0;
            w_gidx = '0;
        end
    end

    assign w_grant    = w_xfer ? (N'(1) << w_gidx) : '0;
    assign w_sel_data = in_data[w_gidx*WIDTH +: WIDTH];
    assign in_ready   = w_grant;

    // Output slot and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_src   <= w_gidx;
            r_out_valid <= 1'b1;
            if (mode) begin
                r_ptr <= (w_gidx == LAST_IDX) ? '0 : w_gidx + SW'(1);
            end else begin
                r_ptr <= r_ptr;
            end
        end else if (w_accept) begin
            // Drained with nothing to replace it: data/src keep last values.
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SW    = 2;

    logic               clk;
    logic               rst_n;
    logic               mode;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_src;
    logic               out_valid;
    logic               out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_data;
    int               m_src;
    logic             m_valid;
    int               m_ptr;
    int               m_grant;
    logic [N-1:0]     exp_ready;

    rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model arbitration: walk the search order, first valid wins.
    task automatic model_arb();
        int order [$];
        m_grant   = -1;
        exp_ready = '0;
        order     = {};
        for (int k = 0; k < N; k++) order.push_back(mode ? (m_ptr + k) % N : k);
        if (rst_n && (!m_valid || out_ready)) begin
            foreach (order[j]) begin
                if (m_grant < 0 && in_valid[order[j]]) m_grant = order[j];
            end
        end
        if (m_grant >= 0) exp_ready[m_grant] = 1'b1;
    endtask

    // Advance one clock: model takes the same edge as the DUT.
    task automatic tick();
        model_arb();
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
        end else if (m_grant >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[m_grant*WIDTH +: WIDTH];
            m_src   = m_grant;
            if (mode) m_ptr = (m_grant + 1) % N;
        end else if (!m_valid || out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic set_data(input logic [WIDTH-1:0] base);
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = base + WIDTH'(i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        set_data(32'h1000_0000);
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready_pre: got %b expected %b", in_ready, 4'b0000);
        end
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 32'h0 || out_src !== 2'd0) begin
            errors++; $display("FAIL reset_data_src: got %h/%0d expected 0/0", out_data, out_src);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b expected %b", in_ready, 4'b0000);
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b1; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        set_data(32'hA000_0000);
        #1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (in_ready !== (4'b0001 << (c % N))) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, in_ready, 4'b0001 << (c % N));
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== SW'(c % N) || out_data !== 32'hA000_0000 + WIDTH'(c % N)) begin
                errors++; $display("FAIL rr_out[%0d]: got v=%b src=%0d data=%h expected v=1 src=%0d", c, out_valid, out_src, out_data, c % N);
            end
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0; in_valid = 4'b0110; out_ready = 1'b1;
        set_data(32'hB000_0000);
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (in_ready !== 4'b0010) begin
                errors++; $display("FAIL fixed_ready[%0d]: got %b expected 0010", c, in_ready);
            end
            tick();
            checks++;
            if (out_src !== 2'd1 || out_valid !== 1'b1 || out_data !== 32'hB000_0001) begin
                errors++; $display("FAIL fixed_out[%0d]: got src=%0d v=%b data=%h expected src=1", c, out_src, out_valid, out_data);
            end
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; in_valid = 4'b0100; out_ready = 1'b1;
        in_data[2*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        tick();
        out_ready = 1'b0; in_valid = 4'b1111; set_data(32'hC000_0000);
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, in_ready);
            end
            checks++;
            if (out_data !== 32'hDEAD_BEEF || out_src !== 2'd2 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: got %h/%0d/%b expected deadbeef/2/1", c, out_data, out_src, out_valid);
            end
            tick();
        end
        out_ready = 1'b1; in_valid = 4'b0001; in_data[0 +: WIDTH] = 32'h1234_5678;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++; $display("FAIL bp_release_ready: got %b expected 0001", in_ready);
        end
        tick();
        checks++;
        if (out_data !== 32'h1234_5678 || out_src !== 2'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release_out: got %h/%0d/%b expected 12345678/0/1", out_data, out_src, out_valid);
        end
    endtask

    task automatic test_wrap_skip();
        logic [N-1:0] exp_seq [3];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b0001;
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
        set_data(32'hD000_0000);
        tick();
        in_valid = 4'b0101;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== exp_seq[c]) begin
                errors++; $display("FAIL wrap_ready[%0d]: got %b expected %b", c, in_ready, exp_seq[c]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; rst_n = 1'b0; in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL midrst_ready: got %b expected 0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++; $display("FAIL midrst_first_grant: got %b expected 0001", in_ready);
        end
        tick();
        checks++;
        if (out_src !== 2'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_out: got src=%0d v=%b expected 0/1", out_src, out_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 31) != 0);
            mode      = 1'($urandom_range(0, 1));
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
            #1;
            model_arb();
            checks++;
            if (in_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, in_ready, exp_ready);
            end
            tick();
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_src !== SW'(m_src)) begin
                errors++; $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
                                   c, out_valid, out_data, out_src, m_valid, m_data, m_src);
            end
        end
    endtask

    initial begin
        m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; m_grant = -1;
        rst_n = 1'b0; mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_fixed();
        test_backpressure();
        test_wrap_skip();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
